// File: rtl/la_pkg.sv
// la_pkg: shared types for the logic-analyzer run-length encoder.
//   LA_DW / LA_CW : default sample and run-counter widths
//   la_word_t     : one output run word {cnt, dat}, cnt = run length - 1
//   la_state_e    : encoder FSM states
package la_pkg;

  localparam int unsigned LA_DW = 8;
  localparam int unsigned LA_CW = 8;

  typedef struct packed {
    logic [LA_CW-1:0] cnt;
    logic [LA_DW-1:0] dat;
  } la_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } la_state_e;

endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: minimal AXI4-Stream bundle.
//   TDATA [DW-1:0], TKEEP [KW-1:0], TLAST, TVALID : source -> destination
//   TREADY                                        : destination -> source
//   modport s : source side (drives payload/valid)
//   modport d : destination side (drives ready)
interface axi4_stream_if #(
  parameter int unsigned DW = 8
) ();

  localparam int unsigned KW = (DW + 7) / 8;

  logic [DW-1:0] TDATA;
  logic [KW-1:0] TKEEP;
  logic          TLAST;
  logic          TVALID;
  logic          TREADY;

  modport s (
    output TDATA,
    output TKEEP,
    output TLAST,
    output TVALID,
    input  TREADY
  );

  modport d (
    input  TDATA,
    input  TKEEP,
    input  TLAST,
    input  TVALID,
    output TREADY
  );

endinterface

// File: rtl/la_rle.sv
// la_rle: run-length encoder between the mask stage and the stream writer.
// Collapses runs of identical samples into {cnt, dat} words (cnt = length-1).
//   ACLK     : stream clock for sti and sto
//   ARESETn  : asynchronous active-low reset
//   sti      : sample input stream (TDATA, TLAST, TVALID, TREADY; TKEEP ignored)
//   sto      : run output stream, TDATA = {cnt, dat}, TKEEP all ones
//   ctl_rst  : synchronous flush of the open run and any pending output
//   cfg_ena  : 1 = encode, 0 = bypass (every sample emitted with cnt = 0)
module la_rle
  import la_pkg::*;
#(
  parameter int unsigned DW = LA_DW,
  parameter int unsigned CW = LA_CW
) (
  input  logic     ACLK,
  input  logic     ARESETn,
  axi4_stream_if.d sti,
  axi4_stream_if.s sto,
  input  logic     ctl_rst,
  input  logic     cfg_ena
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  la_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW-1:0] pend_q, pend_d;
  logic [CW-1:0] ocnt_q, ocnt_d;
  logic [DW-1:0] odat_q, odat_d;
  logic          olast_q, olast_d;
  logic          ovalid_q, ovalid_d;

  logic          slot_free_c;
  logic          in_ready_c;
  logic          in_xfer_c;
  logic          in_match_c;
  logic          cnt_sat_c;
  logic          unused_c;

  // Handshake qualifiers
  assign slot_free_c = ~ovalid_q | sto.TREADY;
  assign in_ready_c  = slot_free_c & (state_q != PEND);
  assign in_xfer_c   = sti.TVALID & in_ready_c;
  assign in_match_c  = (sti.TDATA == dat_q);
  assign cnt_sat_c   = (cnt_q == CNT_MAX);
  assign unused_c    = ^sti.TKEEP;

  assign sti.TREADY = in_ready_c;
  assign sto.TVALID = ovalid_q;
  assign sto.TLAST  = olast_q;
  assign sto.TDATA  = {ocnt_q, odat_q};
  assign sto.TKEEP  = '1;

  // Next-state and output-word logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    pend_d   = pend_q;
    ocnt_d   = ocnt_q;
    odat_d   = odat_q;
    olast_d  = olast_q;
    ovalid_d = ovalid_q & ~sto.TREADY;

    case (state_q)
      IDLE: begin
        if (in_xfer_c) begin
          dat_d = sti.TDATA;
          cnt_d = '0;
          if (!cfg_ena || sti.TLAST) begin
            ovalid_d = 1'b1;
            ocnt_d   = '0;
            odat_d   = sti.TDATA;
            olast_d  = sti.TLAST;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (in_xfer_c) begin
          if (in_match_c && !cnt_sat_c && !sti.TLAST) begin
            cnt_d = CW'(cnt_q + 1'b1);
          end else if (in_match_c && !cnt_sat_c && sti.TLAST) begin
            // Final sample extends the run and closes the packet
            ovalid_d = 1'b1;
            ocnt_d   = CW'(cnt_q + 1'b1);
            odat_d   = dat_q;
            olast_d  = 1'b1;
            state_d  = IDLE;
          end else begin
            // Mismatch or saturated counter: close the run as it stands
            ovalid_d = 1'b1;
            ocnt_d   = cnt_q;
            odat_d   = dat_q;
            olast_d  = 1'b0;
            if (sti.TLAST) begin
              // The TLAST sample becomes its own word one cycle later
              pend_d  = sti.TDATA;
              state_d = PEND;
            end else begin
              dat_d = sti.TDATA;
              cnt_d = '0;
            end
          end
        end
      end

      PEND: begin
        if (slot_free_c) begin
          ovalid_d = 1'b1;
          ocnt_d   = '0;
          odat_d   = pend_q;
          olast_d  = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Flush wins over any transfer in the same cycle
    if (ctl_rst) begin
      state_d  = IDLE;
      cnt_d    = '0;
      dat_d    = '0;
      pend_d   = '0;
      ocnt_d   = '0;
      odat_d   = '0;
      olast_d  = 1'b0;
      ovalid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dat_q    <= '0;
      pend_q   <= '0;
      ocnt_q   <= '0;
      odat_q   <= '0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      pend_q   <= pend_d;
      ocnt_q   <= ocnt_d;
      odat_q   <= odat_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
    end
  end

endmodule

// File: tb/tb_la_rle.sv
// tb_la_rle: randomized self-checking bench for la_rle against a run-splitting
// reference model operating on whole sample lists.
module tb_la_rle;
  import la_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic       last;
    logic [7:0] dat;
  } smp_t;

  typedef logic [16:0] obs_t;  // {last, cnt, dat}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ctl_rst = 1'b0;
  logic cfg_ena = 1'b1;
  logic ready_fixed = 1'b1;
  logic rand_ready = 1'b0;
  logic rr = 1'b1;

  smp_t in_q[$];
  obs_t exp_q[$];
  obs_t got_q[$];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi4_stream_if #(.DW(DW))      sti ();
  axi4_stream_if #(.DW(CW + DW)) sto ();

  assign sto.TREADY = rand_ready ? rr : ready_fixed;

  la_rle #(.DW(DW), .CW(CW)) dut (
    .ACLK   (clk),
    .ARESETn(rst_n),
    .sti    (sti),
    .sto    (sto),
    .ctl_rst(ctl_rst),
    .cfg_ena(cfg_ena)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Random downstream ready
  initial forever begin
    @(negedge clk);
    rr = 1'($urandom_range(0, 1));
  end

  // Output monitor: capture accepted words and check hold-while-stalled
  initial begin
    bit   stall_prev;
    obs_t prev;
    la_word_t w;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        w = sto.TDATA;
        if (stall_prev) begin
          chk("hold_valid", 32'(sto.TVALID), 32'd1);
          chk("hold_word", 32'({sto.TLAST, w.cnt, w.dat}), 32'(prev));
        end
        if (sto.TVALID && sto.TREADY) got_q.push_back({sto.TLAST, w.cnt, w.dat});
        stall_prev = sto.TVALID && !sto.TREADY && !ctl_rst;
        prev = {sto.TLAST, w.cnt, w.dat};
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic last);
    int waited;
    waited = 0;
    @(negedge clk);
    sti.TVALID = 1'b1;
    sti.TDATA  = d;
    sti.TLAST  = last;
    #1;
    while (!sti.TREADY) begin
      waited++;
      if (waited > 50) begin
        chk("tready_timeout", 32'd0, 32'd1);
        sti.TVALID = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    in_q.push_back({last, d});
  endtask

  task automatic idle();
    @(negedge clk);
    sti.TVALID = 1'b0;
    sti.TLAST  = 1'b0;
  endtask

  // Reference: split each packet into maximal equal-value runs, then each run
  // into chunks of at most 2**CW samples; only a packet's final chunk has TLAST.
  function automatic void build_expected(input bit ena);
    int i, j, n, len;
    exp_q.delete();
    n = in_q.size();
    i = 0;
    while (i < n) begin
      if (!ena) begin
        exp_q.push_back({in_q[i].last, 8'd0, in_q[i].dat});
        i++;
      end else begin
        j = i;
        while (j + 1 < n && !in_q[j].last && in_q[j + 1].dat == in_q[i].dat) j++;
        len = j - i + 1;
        while (len > 256) begin
          exp_q.push_back({1'b0, 8'd255, in_q[i].dat});
          len -= 256;
        end
        exp_q.push_back({in_q[j].last, 8'(len - 1), in_q[i].dat});
        i = j + 1;
      end
    end
  endfunction

  task automatic check_phase(input string tag, input bit ena);
    int n;
    rand_ready  = 1'b0;
    ready_fixed = 1'b1;
    repeat (8) @(negedge clk);
    build_expected(ena);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_q();
    in_q.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int nsmp;
    sti.TVALID = 1'b0;
    sti.TDATA  = '0;
    sti.TLAST  = 1'b0;
    sti.TKEEP  = '1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", 32'(sto.TVALID), 32'd0);
    chk("rst_tlast", 32'(sto.TLAST), 32'd0);
    chk("rst_tdata", 32'(sto.TDATA), 32'd0);
    chk("rst_tkeep", 32'(sto.TKEEP), 32'h3);
    chk("rst_tready", 32'(sti.TREADY), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic runs
    send(8'd5, 1'b0); send(8'd5, 1'b0); send(8'd5, 1'b0);
    send(8'd7, 1'b0); send(8'd7, 1'b0); send(8'd9, 1'b1);
    idle();
    check_phase("basic", 1'b1);
    if (got_q.size() == 3) begin
      chk("basic_c0", 32'(got_q[0]), 32'({1'b0, 8'd2, 8'd5}));
      chk("basic_c1", 32'(got_q[1]), 32'({1'b0, 8'd1, 8'd7}));
      chk("basic_c2", 32'(got_q[2]), 32'({1'b1, 8'd0, 8'd9}));
    end
    clear_q();

    // Counter saturation
    for (int i = 0; i < 300; i++) send(8'h3C, 1'b0);
    send(8'h3C, 1'b1);
    idle();
    check_phase("sat", 1'b1);
    if (got_q.size() == 2) begin
      chk("sat_c0", 32'(got_q[0]), 32'({1'b0, 8'd255, 8'h3C}));
      chk("sat_c1", 32'(got_q[1]), 32'({1'b1, 8'd44, 8'h3C}));
    end
    clear_q();

    // Mismatch on TLAST forces one PEND cycle
    send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd2, 1'b1);
    @(negedge clk);
    sti.TVALID = 1'b0;
    sti.TLAST  = 1'b0;
    #1;
    chk("pend_tready", 32'(sti.TREADY), 32'd0);
    chk("pend_out0", 32'({sto.TVALID, sto.TLAST, sto.TDATA}), 32'({1'b1, 1'b0, 8'd1, 8'd1}));
    @(negedge clk);
    #1;
    chk("pend_tready_back", 32'(sti.TREADY), 32'd1);
    chk("pend_out1", 32'({sto.TVALID, sto.TLAST, sto.TDATA}), 32'({1'b1, 1'b1, 8'd0, 8'd2}));
    check_phase("pend", 1'b1);
    clear_q();

    // Random samples with random backpressure
    rand_ready = 1'b1;
    nsmp = 10000;
    for (int i = 0; i < nsmp; i++)
      send(8'($urandom_range(0, 3)), (i == nsmp - 1) || ($urandom_range(0, 31) == 0));
    idle();
    check_phase("rand", 1'b1);
    clear_q();

    // Bypass
    cfg_ena = 1'b0;
    send(8'd6, 1'b0); send(8'd6, 1'b0); send(8'd6, 1'b0);
    idle();
    check_phase("bypass", 1'b0);
    if (got_q.size() == 3)
      chk("bypass_c2", 32'(got_q[2]), 32'({1'b0, 8'd0, 8'd6}));
    cfg_ena = 1'b1;
    clear_q();

    // Asynchronous reset mid-run with a stalled output word
    ready_fixed = 1'b0;
    send(8'd4, 1'b0); send(8'd4, 1'b0); send(8'd4, 1'b0); send(8'd5, 1'b0);
    idle();
    #1;
    chk("arst_pre_valid", 32'(sto.TVALID), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(sto.TVALID), 32'd0);
    chk("arst_tdata", 32'(sto.TDATA), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_fixed = 1'b1;
    clear_q();
    send(8'd8, 1'b1);
    idle();
    check_phase("arst", 1'b1);
    if (got_q.size() == 1)
      chk("arst_c0", 32'(got_q[0]), 32'({1'b1, 8'd0, 8'd8}));
    clear_q();

    // Synchronous flush with an open run and a pending word
    ready_fixed = 1'b0;
    send(8'd3, 1'b0); send(8'd3, 1'b0); send(8'd3, 1'b0); send(8'd2, 1'b0);
    idle();
    ctl_rst = 1'b1;
    @(negedge clk);
    ctl_rst = 1'b0;
    #1;
    chk("flush_valid", 32'(sto.TVALID), 32'd0);
    chk("flush_tdata", 32'(sto.TDATA), 32'd0);
    ready_fixed = 1'b1;
    clear_q();
    send(8'd9, 1'b1);
    idle();
    check_phase("flush", 1'b1);
    if (got_q.size() == 1)
      chk("flush_c0", 32'(got_q[0]), 32'({1'b1, 8'd0, 8'd9}));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/la_rle.md
Name: la_rle

Overview:
- Run-length encoder for the logic-analyzer acquisition path.
- Sits directly downstream of the binary AND mask stage.
- Consumes the masked sample stream and collapses runs of identical samples into one word {count, data}. This saves acquisition buffer bandwidth for slowly changing digital inputs.
- Its output feeds the stream-to-memory writer.

Parameters:
- DW, 8, sample data width in bits (matches the mask stage data type width).
- CW, 8, run counter width in bits; one output word describes up to 2**CW samples.

Ports:
- ACLK  input  1  stream clock, shared by sti and sto.
- ARESETn  input  1  reset, asynchronous, active-low.
- sti  axi4_stream_if.d  DW  input sample stream; uses TDATA, TLAST, TVALID, TREADY; TKEEP is ignored.
- sto  axi4_stream_if.s  CW+DW  output run stream; TDATA = {cnt, dat}, where cnt = run length minus 1; also TLAST, TVALID, TKEEP.
- ctl_rst  input  1  synchronous flush: discards the open run and any pending output.
- cfg_ena  input  1  1 = encode; 0 = bypass, where every sample is emitted with cnt=0.

Behaviour:
- Reset (ARESETn low, asynchronous):
  - sto.TVALID=0, sto.TLAST=0, sto.TDATA=0.
  - Internal run_open=0, cnt_r=0, dat_r=0, FSM in IDLE.
- ctl_rst=1 at a clock edge: same values as reset. Takes priority over any transfer in that cycle.
- sto.TKEEP is constant all-ones.
- Input transfer: sti.TVALID & sti.TREADY.
- Output slot free: ~sto.TVALID | sto.TREADY.
- sti.TREADY = slot_free & (state != PEND).
- sto.TVALID, once set, holds with TDATA/TLAST stable until sto.TREADY.
- FSM states:
  - IDLE: no open run.
    - On transfer: dat_r<=in, cnt_r<=0.
    - If TLAST=1: emit {0,in} with TLAST=1 and stay in IDLE.
    - Otherwise go to RUN.
  - RUN: open run.
    - Transfer, in==dat_r, cnt_r != 2**CW-1, TLAST=0: cnt_r<=cnt_r+1. No output.
    - Transfer, in==dat_r, TLAST=1: emit {cnt_r+1,dat_r} with TLAST=1 and go to IDLE.
      - If cnt_r == 2**CW-1, instead: emit {cnt_r,dat_r} TLAST=0, then go to PEND with pend_word={0,in} TLAST=1.
    - Transfer, in==dat_r, cnt_r == 2**CW-1, TLAST=0 (saturation): emit {cnt_r,dat_r} TLAST=0; cnt_r<=0; stay in RUN.
    - Transfer, in!=dat_r, TLAST=0: emit {cnt_r,dat_r} TLAST=0; dat_r<=in, cnt_r<=0; stay in RUN.
    - Transfer, in!=dat_r, TLAST=1: emit old run TLAST=0; go to PEND with pend_word={0,in} TLAST=1.
  - PEND: sti.TREADY=0. When the slot is free: emit pend_word, then go to IDLE.
- Latency:
  - Emitted words are registered and appear on sto one cycle after the causing input transfer (or PEND cycle).
  - An open run without TLAST is never emitted spontaneously. A run ends only on mismatch, saturation, TLAST or flush.
- Bypass (cfg_ena=0):
  - Every transfer emits {0,in} with in's TLAST; FSM stays IDLE.
  - cfg_ena must only change while no run is open; behaviour otherwise is undefined. The bench does not test this.
- Count arithmetic is unsigned modulo-free: the counter never wraps, saturation is handled above.
- Throughput: one sample per cycle with sto.TREADY=1, except the PEND cycle.

Decomposition:
- Package la_pkg holds:
  - typedef of the output word as a packed struct {logic [CW-1:0] cnt; logic [DW-1:0] dat;};
  - FSM state enum {IDLE, RUN, PEND}.
- No sub-module: the output register and FSM live in one module, ~150-200 lines.

Test Plan:
- Stream 5,5,5,7,7,9(TLAST) with sto.TREADY=1 -> outputs {2,5},{1,7},{0,9} with TLAST only on the last word.
- Stream 300 samples of 0x3C then 0x3C(TLAST) with CW=8 -> {255,0x3C} then {44,0x3C} with TLAST=1.
- Stream 1,1,2(TLAST) -> {1,1} TLAST=0, then one PEND cycle with sti.TREADY=0, then {0,2} TLAST=1.
- Random sto.TREADY (50%) over 10k random samples with values 0..3 -> expanding the output stream reproduces the input exactly; TDATA stable while TVALID & ~TREADY.
- Assert ARESETn low mid-run (after 4,4,4) -> sto.TVALID drops immediately, asynchronously. After release, input 8(TLAST) yields only {0,8}.
- cfg_ena=0, stream 6,6,6 -> three words {0,6}.
- ctl_rst pulse during an open run -> that run is discarded and never emitted.
